// File: rtl/regfile_sched_pkg.sv
// Shared types and defaults for the dual-issue register-file scoreboard.
package regfile_sched_pkg;

  localparam int NREG_DEF    = 32;
  localparam int MAXPEND_DEF = 4;

  typedef logic [4:0] regaddr_t;

  typedef struct packed {
    logic     valid;
    regaddr_t rs1;
    regaddr_t rs2;
    regaddr_t rd;
    logic     rd_we;
    logic     long;
  } slot_t;

  // Only long ops that really write a non-zero register occupy a pending slot.
  function automatic logic is_tracked(slot_t s);
    return s.long && s.rd_we && (s.rd != '0);
  endfunction

endpackage

// File: rtl/sb_hazard_check.sv
// Per-slot hazard check against scoreboard state, completion port and pending capacity.
module sb_hazard_check
  import regfile_sched_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int MAXPEND = MAXPEND_DEF
) (
  input  slot_t                         slot,
  input  logic                          flush,
  input  logic [NREG-1:0]               busy_eff,
  input  logic [NREG-1:0]               busy_vec,
  input  logic                          cmpl_valid,
  input  regaddr_t                      cmpl_rd,
  input  logic [$clog2(MAXPEND+1):0]    pend_base,
  output logic                          ok,
  output logic                          tracked
);

  localparam int CW = $clog2(MAXPEND+1);
  localparam logic [CW:0] MAXP = (CW+1)'(MAXPEND);

  always_comb begin
    tracked = is_tracked(slot);
    ok      = slot.valid && !flush;
    // Sources see the same-cycle completion through the register-file bypass.
    if (slot.rs1 != '0 && busy_eff[slot.rs1]) ok = 1'b0;
    if (slot.rs2 != '0 && busy_eff[slot.rs2]) ok = 1'b0;
    // The destination must not be in flight nor written back on this same edge.
    if (slot.rd_we && slot.rd != '0) begin
      if (busy_vec[slot.rd])                   ok = 1'b0;
      if (cmpl_valid && cmpl_rd == slot.rd)    ok = 1'b0;
    end
    if (tracked && pend_base >= MAXP) ok = 1'b0;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Dual-issue scoreboard: in-order issue grants for a pair of decoded ops plus
// busy tracking of outstanding long-latency writes.
module regfile_scoreboard
  import regfile_sched_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int MAXPEND = MAXPEND_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid0,
  input  logic [4:0]                    rs1_0,
  input  logic [4:0]                    rs2_0,
  input  logic [4:0]                    rd_0,
  input  logic                          rd_we0,
  input  logic                          long0,
  input  logic                          in_valid1,
  input  logic [4:0]                    rs1_1,
  input  logic [4:0]                    rs2_1,
  input  logic [4:0]                    rd_1,
  input  logic                          rd_we1,
  input  logic                          long1,
  input  logic                          flush,
  input  logic                          cmpl_valid,
  input  logic [4:0]                    cmpl_rd,
  output logic                          issue0,
  output logic                          issue1,
  output logic [NREG-1:0]               busy_vec,
  output logic [$clog2(MAXPEND+1)-1:0]  pend_count,
  output logic                          err
);

  localparam int CW = $clog2(MAXPEND+1);

  slot_t           s0, s1;
  logic [NREG-1:0] busy_eff, busy_nxt;
  logic [CW:0]     pend_base0, pend_base1;
  logic            ok0, ok1, trk0, trk1;
  logic            raw1, waw1, cmpl_hit, cmpl_spur;

  assign s0 = {in_valid0, rs1_0, rs2_0, rd_0, rd_we0, long0};
  assign s1 = {in_valid1, rs1_1, rs2_1, rd_1, rd_we1, long1};

  always_comb begin
    busy_eff = busy_vec;
    if (cmpl_valid) busy_eff[cmpl_rd] = 1'b0;
  end

  assign pend_base0 = {1'b0, pend_count};
  assign pend_base1 = {1'b0, pend_count} + (CW+1)'(trk0);

  sb_hazard_check #(.NREG(NREG), .MAXPEND(MAXPEND)) u_chk0 (
    .slot(s0), .flush(flush), .busy_eff(busy_eff), .busy_vec(busy_vec),
    .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd), .pend_base(pend_base0),
    .ok(ok0), .tracked(trk0)
  );

  sb_hazard_check #(.NREG(NREG), .MAXPEND(MAXPEND)) u_chk1 (
    .slot(s1), .flush(flush), .busy_eff(busy_eff), .busy_vec(busy_vec),
    .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd), .pend_base(pend_base1),
    .ok(ok1), .tracked(trk1)
  );

  // Grant semantics: issueN is a same-cycle acceptance of slot N. The producer
  // must hold a slot (and its younger partner) stable until it is granted;
  // slot 1 is only ever granted together with slot 0, never on its own.
  assign raw1   = rd_we0 && (rd_0 != '0) && ((rs1_1 == rd_0) || (rs2_1 == rd_0));
  assign waw1   = rd_we0 && rd_we1 && (rd_0 != '0) && (rd_1 == rd_0);
  assign issue0 = ok0;
  assign issue1 = ok0 && ok1 && !raw1 && !waw1 && !(long0 && long1);

  assign cmpl_hit  = cmpl_valid && (cmpl_rd != '0) &&  busy_vec[cmpl_rd];
  assign cmpl_spur = cmpl_valid && (cmpl_rd != '0) && !busy_vec[cmpl_rd];

  always_comb begin
    busy_nxt = busy_vec;
    if (cmpl_hit)       busy_nxt[cmpl_rd] = 1'b0;
    if (issue0 && trk0) busy_nxt[rd_0]    = 1'b1;
    if (issue1 && trk1) busy_nxt[rd_1]    = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_vec   <= '0;
      pend_count <= '0;
      err        <= 1'b0;
    end else begin
      busy_vec   <= busy_nxt;
      pend_count <= pend_count + CW'(issue0 && trk0) + CW'(issue1 && trk1)
                    - CW'(cmpl_hit);
      if (cmpl_spur) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: pair-rule table plus multi-cycle sequences.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid0, rd_we0, long0, in_valid1, rd_we1, long1;
  logic [4:0]  rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1, cmpl_rd;
  logic        flush, cmpl_valid;
  logic        issue0, issue1, err;
  logic [31:0] busy_vec;
  logic [2:0]  pend_count;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid0(in_valid0), .rs1_0(rs1_0), .rs2_0(rs2_0), .rd_0(rd_0),
    .rd_we0(rd_we0), .long0(long0),
    .in_valid1(in_valid1), .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
    .rd_we1(rd_we1), .long1(long1),
    .flush(flush), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .issue0(issue0), .issue1(issue1), .busy_vec(busy_vec),
    .pend_count(pend_count), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [4:0] a0, b0, d0;
    logic       we0, l0;
    logic       v1;
    logic [4:0] a1, b1, d1;
    logic       we1, l1;
    logic       fl;
    logic       e0, e1;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    in_valid0 = 0; rs1_0 = 0; rs2_0 = 0; rd_0 = 0; rd_we0 = 0; long0 = 0;
    in_valid1 = 0; rs1_1 = 0; rs2_1 = 0; rd_1 = 0; rd_we1 = 0; long1 = 0;
    flush = 0; cmpl_valid = 0; cmpl_rd = 0;
  endtask

  task automatic slot0(input int a, input int b, input int d, input logic we, input logic l);
    in_valid0 = 1; rs1_0 = 5'(a); rs2_0 = 5'(b); rd_0 = 5'(d); rd_we0 = we; long0 = l;
  endtask

  task automatic slot1(input int a, input int b, input int d, input logic we, input logic l);
    in_valid1 = 1; rs1_1 = 5'(a); rs2_1 = 5'(b); rd_1 = 5'(d); rd_we1 = we; long1 = l;
  endtask

  task automatic cmpl(input int d);
    cmpl_valid = 1; cmpl_rd = 5'(d);
  endtask

  task automatic drive(input vec_t v);
    idle();
    in_valid0 = v.v0; rs1_0 = v.a0; rs2_0 = v.b0; rd_0 = v.d0; rd_we0 = v.we0; long0 = v.l0;
    in_valid1 = v.v1; rs1_1 = v.a1; rs2_1 = v.b1; rd_1 = v.d1; rd_we1 = v.we1; long1 = v.l1;
    flush = v.fl;
  endtask

  task automatic new_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    // v0 a0 b0 d0 we0 l0 | v1 a1 b1 d1 we1 l1 | fl | e0 e1
    vt[0] = '{1, 1, 2, 3, 1, 0,  1, 4, 3, 8, 1, 0,  0,  1, 0}; // RAW on rs2_1
    vt[1] = '{1, 1, 2, 3, 1, 0,  1, 4, 5, 8, 1, 0,  0,  1, 1}; // independent
    vt[2] = '{1, 1, 2, 7, 1, 0,  1, 4, 5, 7, 1, 0,  0,  1, 0}; // WAW in pair
    vt[3] = '{0, 1, 2, 3, 1, 0,  1, 4, 5, 8, 1, 0,  0,  0, 0}; // slot 1 never alone
    vt[4] = '{1, 1, 2, 3, 1, 0,  1, 4, 5, 8, 1, 0,  1,  0, 0}; // flush
    vt[5] = '{1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0,  0,  1, 1}; // x0 never conflicts
    vt[6] = '{1, 1, 2, 3, 0, 1,  1, 4, 5, 8, 0, 1,  0,  1, 0}; // two long ops
    vt[7] = '{1, 1, 2, 3, 0, 0,  1, 3, 3, 3, 1, 0,  0,  1, 1}; // no write in slot 0
    vt[8] = '{1, 1, 2, 9, 1, 0,  1, 4, 5, 9, 0, 0,  0,  1, 1}; // slot 1 does not write
    vt[9] = '{1, 3, 2, 3, 1, 0,  1, 4, 5, 8, 1, 0,  0,  1, 1}; // slot 0 reads own rd

    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("reset busy_vec", busy_vec, 0);
    check("reset pend_count", 32'(pend_count), 0);
    check("reset err", 32'(err), 0);
    check("reset issue0", 32'(issue0), 0);
    check("reset issue1", 32'(issue1), 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      check($sformatf("vec%0d issue0", i), 32'(issue0), 32'(vt[i].e0));
      check($sformatf("vec%0d issue1", i), 32'(issue1), 32'(vt[i].e1));
    end
    new_cycle(); #1;
    check("table busy_vec", busy_vec, 0);
    check("table pend_count", 32'(pend_count), 0);

    // long-op RAW stall, then bypass on the completion cycle
    new_cycle(); slot0(1, 0, 5, 1, 1); #1;
    check("raw load issue0", 32'(issue0), 1);
    new_cycle(); slot0(5, 0, 6, 1, 0); #1;
    check("raw busy_vec", busy_vec, 32'h20);
    check("raw pend_count", 32'(pend_count), 1);
    check("raw stall c1", 32'(issue0), 0);
    new_cycle(); slot0(5, 0, 6, 1, 0); #1;
    check("raw stall c2", 32'(issue0), 0);
    new_cycle(); slot0(5, 0, 6, 1, 0); cmpl(5); #1;
    check("raw bypass issue0", 32'(issue0), 1);
    new_cycle(); #1;
    check("raw cleared busy", busy_vec, 0);
    check("raw cleared pend", 32'(pend_count), 0);
    check("raw err", 32'(err), 0);

    // capacity
    for (int r = 1; r <= 4; r++) begin
      new_cycle(); slot0(0, 0, r, 1, 1); #1;
      check($sformatf("cap load%0d issue0", r), 32'(issue0), 1);
    end
    new_cycle(); slot0(0, 0, 6, 1, 1); cmpl(2); #1;
    check("cap full pend", 32'(pend_count), 4);
    check("cap full busy", busy_vec, 32'h1E);
    check("cap fifth stalled", 32'(issue0), 0);
    new_cycle(); slot0(0, 0, 6, 1, 1); #1;
    check("cap after cmpl pend", 32'(pend_count), 3);
    check("cap after cmpl busy", busy_vec, 32'h1A);
    check("cap fifth issues", 32'(issue0), 1);
    new_cycle(); slot0(7, 0, 8, 1, 0); slot1(0, 0, 10, 1, 1); #1;
    check("cap refill pend", 32'(pend_count), 4);
    check("cap refill busy", busy_vec, 32'h5A);
    check("cap slot1 short ok", 32'(issue0), 1);
    check("cap slot1 load full", 32'(issue1), 0);
    new_cycle(); slot0(0, 0, 4, 1, 0); #1;
    check("waw busy rd stall", 32'(issue0), 0);
    new_cycle(); cmpl(1); #1;
    new_cycle(); slot0(7, 0, 8, 1, 0); slot1(0, 0, 11, 1, 1); #1;
    check("cap slot1 load pend3", 32'(issue1), 1);
    new_cycle(); cmpl(3); #1;
    check("cap slot1 busy", busy_vec, 32'h858);
    check("cap slot1 pend", 32'(pend_count), 4);
    new_cycle(); cmpl(4);
    new_cycle(); cmpl(6);
    new_cycle(); cmpl(11);
    new_cycle(); #1;
    check("cap drained busy", busy_vec, 0);
    check("cap drained pend", 32'(pend_count), 0);
    check("cap drained err", 32'(err), 0);

    // flush blocks issue but completions still retire
    new_cycle(); slot0(0, 0, 12, 1, 1); #1;
    check("flush load issue0", 32'(issue0), 1);
    new_cycle(); flush = 1; slot0(1, 2, 3, 1, 0); slot1(4, 5, 8, 1, 0); cmpl(12); #1;
    check("flush issue0", 32'(issue0), 0);
    check("flush issue1", 32'(issue1), 0);
    new_cycle(); #1;
    check("flush busy cleared", busy_vec, 0);
    check("flush pend cleared", 32'(pend_count), 0);

    // two tracked long ops in one pair
    new_cycle(); slot0(0, 0, 10, 1, 1); slot1(0, 0, 11, 1, 1); #1;
    check("dual long issue0", 32'(issue0), 1);
    check("dual long issue1", 32'(issue1), 0);
    new_cycle(); cmpl(10); #1;
    check("dual long busy", busy_vec, 32'h400);
    check("dual long pend", 32'(pend_count), 1);
    new_cycle(); #1;
    check("dual long drained", 32'(pend_count), 0);

    // register 0 and spurious completion
    new_cycle(); slot0(0, 0, 0, 1, 1); #1;
    check("x0 long issue0", 32'(issue0), 1);
    new_cycle(); cmpl(0); #1;
    check("x0 long busy", busy_vec, 0);
    check("x0 long pend", 32'(pend_count), 0);
    new_cycle(); cmpl(9); #1;
    check("x0 cmpl no err", 32'(err), 0);
    new_cycle(); slot0(0, 0, 13, 1, 1); #1;
    check("spur err set", 32'(err), 1);
    check("spur pend", 32'(pend_count), 0);
    new_cycle(); new_cycle(); #1;
    check("spur err sticky", 32'(err), 1);
    check("pre-reset busy", busy_vec, 32'h2000);

    // reset mid-operation clears everything
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; #1;
    check("rereset err", 32'(err), 0);
    check("rereset busy", busy_vec, 0);
    check("rereset pend", 32'(pend_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
